mem_fill_arbiter: RTL and testbench
===================================

Name: mem_fill_arbiter

Overview:
- Shares one multi-cycle, single-ported unified memory between the I-cache miss path and the D-cache miss/write path.
- On a grant it runs either a full cache-block fill (BLOCK_WORDS sequential word reads) or a single-word D-side write.
- Read data returns to the winning requester with a word index.
- Sits between the two caches and the unified memory model; replaces the separate instruction and data memories of the single-cycle datapath.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- BLOCK_WORDS, 8, words per cache block; power of 2; words are 2 bytes apart.
- IDX_W, 3, log2(BLOCK_WORDS).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ic_req  in  1  I-cache miss request; held until ic_done
- ic_addr  in  ADDR_W  I-side miss byte address
- ic_grant  out  1  I-side owns memory
- ic_data_vld  out  1  fill_data valid for I-side
- ic_word  out  IDX_W  word index of current fill_data
- ic_done  out  1  one-cycle pulse, I-side transaction complete
- dc_req  in  1  D-cache request; held until dc_done
- dc_wr  in  1  with dc_req: 1 = single-word write, 0 = block fill
- dc_addr  in  ADDR_W  D-side byte address
- dc_wdata  in  DATA_W  D-side write data
- dc_grant  out  1  D-side owns memory
- dc_data_vld  out  1  fill_data valid for D-side
- dc_word  out  IDX_W  word index of current fill_data
- dc_done  out  1  one-cycle pulse, D-side transaction complete
- fill_data  out  DATA_W  returned word; passes mem_rdata straight through
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_data_valid  in  1  mem_rdata valid; fixed latency after each issue

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset: state IDLE; all counters 0; every output 0. Reset asserted mid-transaction aborts it immediately; the abort is not reported to either requester.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - Samples requests. dc_req has priority over ic_req.
  - Winner latched; block base = addr with low log2(BLOCK_WORDS)+1 bits cleared.
  - Goes to WRITE if dc_wr=1, else to ISSUE.
- ISSUE:
  - Winner's grant=1.
  - mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - issue_cnt runs 0..BLOCK_WORDS-1 on consecutive cycles, then the FSM enters DRAIN.
- Address arithmetic: the word offset is inserted into the low bits only; no carry into upper bits. Example: base 0xFFF0 issues 0xFFF0..0xFFFE.
- Returned data (valid in ISSUE or DRAIN):
  - Each mem_data_valid drives winner's data_vld=1 combinationally, with word = recv_cnt.
  - recv_cnt then increments.
  - mem_data_valid in IDLE, WRITE or DONE is ignored and nothing is forwarded.
- DRAIN: grant held high; mem_en=0. When the BLOCK_WORDS-th return arrives, next state is DONE.
- WRITE:
  - One cycle with dc_grant=1, mem_en=1, mem_wr=1, mem_addr=dc_addr (bit0 cleared), mem_wdata=dc_wdata.
  - Next state DONE.
- DONE:
  - Winner's done=1 and grant=1 for exactly one cycle; next state IDLE.
  - At least one IDLE cycle always separates transactions.
- Requester protocol:
  - A requester dropping req mid-transaction does not abort it; done is still pulsed.
  - A req still high in IDLE after done starts a new transaction.
- mem_wdata = 0 whenever mem_wr = 0.
- At most one grant is high at any time.
- data_vld and done are never asserted for a non-granted side.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are present in IDLE, the side not served last wins. The last-served flag resets to I-side, so D-side wins the first tie.
- Undefined: fixed D-over-I priority. Under continuous D-side requests the I-side may starve.

Test Plan:
- I-side fill, ic_addr=0x1234, memory latency 4 -> ic_grant high; mem_addr 0x1230,0x1232,...,0x123E on 8 consecutive cycles; 8 ic_data_vld pulses with ic_word 0..7 matching memory contents; ic_done one cycle after the last return; dc_* outputs stay 0.
- ic_req and dc_req (fill, 0x0200) raised in the same cycle -> D-side fill 0x0200..0x020E completes with dc_done; after one IDLE cycle, I-side is granted.
- D-side write dc_wr=1, dc_addr=0x0041, dc_wdata=0xBEEF -> exactly one cycle of mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF; dc_done next cycle; no dc_data_vld.
- D-side fill at 0xFFF6 -> addresses 0xFFF0..0xFFFE, never 0x0000; 8 dc_data_vld pulses.
- rst_n low after 3 returned words of an I-side fill -> all outputs 0 asynchronously; after release with ic_req still high, a fresh fill restarts from word 0 (mem_addr = base).
- With ARB_RR_EN defined and both requests held continuously -> grants alternate D, I, D, I; without ARB_RR_EN -> D-side granted every transaction.

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// ============================================================================
// Module   : mem_fill_arbiter
// Purpose  : Shares one fixed-latency single-ported memory between the I-cache
//            fill path and the D-cache fill/write path. Optional round-robin
//            arbitration is enabled with macro ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int IDX_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_data_vld,
  output logic [IDX_W-1:0]  ic_word,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_grant,
  output logic              dc_data_vld,
  output logic [IDX_W-1:0]  dc_word,
  output logic              dc_done,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);

  localparam int OFS_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_side_d;
  logic [ADDR_W-1:0]   r_base;
  logic [DATA_W-1:0]   r_wdata;
  logic [IDX_W-1:0]    r_issue_cnt;
  logic [IDX_W-1:0]    r_recv_cnt;
  logic                w_pick_d;
  logic                w_start;
  logic                w_ret;
  logic                w_busy;
  logic                w_unused;

  assign w_start = ic_req | dc_req;

`ifdef ARB_RR_EN
  // Last-served flag: 0 = I-side, so the first tie goes to the D-side.
  logic r_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_last_d <= w_pick_d;
    end
  end

  assign w_pick_d = dc_req & (~ic_req | ~r_last_d);
`else
  assign w_pick_d = dc_req;
`endif

  // Returns are only meaningful while a fill is in flight.
  assign w_ret    = mem_data_valid & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
  assign w_busy   = (r_state != S_IDLE);
  assign w_unused = ^{ic_addr[OFS_W-1:0], dc_addr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_side_d    <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_start) begin
        r_side_d    <= w_pick_d;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        if (w_pick_d && dc_wr) begin
          r_base  <= {dc_addr[ADDR_W-1:1], 1'b0};
          r_wdata <= dc_wdata;
        end else begin
          r_base  <= w_pick_d ? {dc_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}}
                              : {ic_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          r_wdata <= '0;
        end
      end
      if (r_state == S_ISSUE) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_ret) begin
        r_recv_cnt <= r_recv_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    ic_grant    = w_busy & ~r_side_d;
    dc_grant    = w_busy & r_side_d;
    ic_data_vld = w_ret & ~r_side_d;
    dc_data_vld = w_ret & r_side_d;
    ic_word     = (w_ret & ~r_side_d) ? r_recv_cnt : '0;
    dc_word     = (w_ret & r_side_d) ? r_recv_cnt : '0;
    ic_done     = 1'b0;
    dc_done     = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = mem_rdata;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = (w_pick_d && dc_wr) ? S_WRITE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        // Offset replaces the low bits only; no carry into the block address.
        mem_addr = {r_base[ADDR_W-1:OFS_W], r_issue_cnt, 1'b0};
        if (r_issue_cnt == C_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_ret && r_recv_cnt == C_LAST) begin
          w_next = S_DONE;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_base;
        mem_wdata = r_wdata;
        w_next    = S_DONE;
      end
      S_DONE: begin
        ic_done = ~r_side_d;
        dc_done = r_side_d;
        w_next  = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
// ============================================================================
// Module   : tb_mem_fill_arbiter
// Purpose  : Directed self-checking bench for mem_fill_arbiter with a
//            fixed-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_fill_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req = 1'b0;
  logic [15:0] ic_addr = '0;
  logic        ic_grant, ic_data_vld, ic_done;
  logic [2:0]  ic_word;
  logic        dc_req = 1'b0;
  logic        dc_wr = 1'b0;
  logic [15:0] dc_addr = '0;
  logic [15:0] dc_wdata = '0;
  logic        dc_grant, dc_data_vld, dc_done;
  logic [2:0]  dc_word;
  logic [15:0] fill_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;

  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant),
    .ic_data_vld(ic_data_vld), .ic_word(ic_word), .ic_done(ic_done),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_grant(dc_grant), .dc_data_vld(dc_data_vld), .dc_word(dc_word),
    .dc_done(dc_done), .fill_data(fill_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_data_valid(mem_data_valid)
  );

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Fixed-latency read pipeline, flushed together with the DUT reset.
  logic [LAT-1:0] pv;
  logic [15:0]    pa [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
  end
  assign mem_data_valid = pv[LAT-1];
  assign mem_rdata      = pv[LAT-1] ? mem_val(pa[LAT-1]) : 16'h0000;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q_iss[$];
  logic [18:0] q_ic_ret[$];
  logic [18:0] q_dc_ret[$];
  logic [31:0] q_wr[$];
  bit          q_grant[$];
  int ic_done_cnt, dc_done_cnt, ic_done_cyc, dc_done_cyc;
  int ic_last_ret, dc_last_ret, ic_rise, wr_cyc, n_viol, cyc;
  bit p_ic_g, p_dc_g;

  always @(negedge clk) begin
    if (mem_en && !mem_wr) q_iss.push_back(mem_addr);
    if (mem_en && mem_wr) begin
      q_wr.push_back({mem_addr, mem_wdata});
      wr_cyc = cyc;
    end
    if (ic_data_vld) begin
      q_ic_ret.push_back({ic_word, fill_data});
      ic_last_ret = cyc;
    end
    if (dc_data_vld) begin
      q_dc_ret.push_back({dc_word, fill_data});
      dc_last_ret = cyc;
    end
    if (ic_done) begin ic_done_cnt++; ic_done_cyc = cyc; end
    if (dc_done) begin dc_done_cnt++; dc_done_cyc = cyc; end
    if (ic_grant && !p_ic_g) begin q_grant.push_back(1'b0); ic_rise = cyc; end
    if (dc_grant && !p_dc_g) q_grant.push_back(1'b1);
    if (ic_grant && dc_grant) n_viol++;
    if ((ic_data_vld || ic_done) && !ic_grant) n_viol++;
    if ((dc_data_vld || dc_done) && !dc_grant) n_viol++;
    if (!mem_wr && mem_wdata !== 16'h0000) n_viol++;
    p_ic_g = ic_grant;
    p_dc_g = dc_grant;
    cyc++;
  end

  task automatic clear_mon();
    q_iss.delete(); q_ic_ret.delete(); q_dc_ret.delete();
    q_wr.delete(); q_grant.delete();
    ic_done_cnt = 0; dc_done_cnt = 0; n_viol = 0;
    ic_done_cyc = -1; dc_done_cyc = -1; ic_rise = -1; wr_cyc = -1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input bit side_d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = side_d ? (dc_done_cnt > 0) : (ic_done_cnt > 0);
    end
  endtask

  function automatic logic [71:0] out_vec();
    return {ic_grant, ic_data_vld, ic_word, ic_done, dc_grant, dc_data_vld,
            dc_word, dc_done, mem_en, mem_wr, mem_addr, mem_wdata, fill_data};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_vec++;
    if (out_vec() !== 72'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", out_vec());
    end
    rst_n = 1'b1;
    repeat (3) step();
    n_vec++;
    if (out_vec() !== 72'd0) begin
      n_err++; $display("FAIL idle_outputs: got %h expected 0", out_vec());
    end
  endtask

  task automatic test_ic_fill();
    bit ok;
    clear_mon();
    ic_addr = 16'h1234; ic_req = 1'b1;
    wait_done(1'b0, ok);
    ic_req = 1'b0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ic_fill_timeout: got no ic_done expected ic_done"); end
    n_vec++;
    if (q_iss.size() != 8) begin
      n_err++; $display("FAIL ic_fill_issues: got %0d expected 8", q_iss.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (q_iss[i] !== 16'h1230 + 16'(2*i)) begin
          n_err++; $display("FAIL ic_fill_addr[%0d]: got %h expected %h", i, q_iss[i], 16'h1230 + 16'(2*i));
        end
      end
    end
    n_vec++;
    if (q_ic_ret.size() != 8) begin
      n_err++; $display("FAIL ic_fill_returns: got %0d expected 8", q_ic_ret.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (q_ic_ret[i] !== {3'(i), mem_val(16'h1230 + 16'(2*i))}) begin
          n_err++; $display("FAIL ic_fill_data[%0d]: got %h expected %h", i, q_ic_ret[i], {3'(i), mem_val(16'h1230 + 16'(2*i))});
        end
      end
    end
    n_vec++;
    if (ic_done_cyc != ic_last_ret + 1) begin
      n_err++; $display("FAIL ic_done_timing: got cycle %0d expected %0d", ic_done_cyc, ic_last_ret + 1);
    end
    n_vec++;
    if (q_dc_ret.size() != 0 || dc_done_cnt != 0 || q_grant.size() != 1 || n_viol != 0) begin
      n_err++; $display("FAIL ic_fill_dc_quiet: got dc_ret=%0d dc_done=%0d grants=%0d viol=%0d expected 0,0,1,0",
                        q_dc_ret.size(), dc_done_cnt, q_grant.size(), n_viol);
    end
    repeat (2) step();
  endtask

  task automatic test_tie();
    bit ok;
    clear_mon();
    ic_addr = 16'h1234; ic_req = 1'b1;
    dc_addr = 16'h0200; dc_wr = 1'b0; dc_req = 1'b1;
    wait_done(1'b1, ok);
    dc_req = 1'b0;
    n_vec++;
    if (!ok || ic_done_cnt != 0) begin
      n_err++; $display("FAIL tie_dc_first: got dc_done=%0d ic_done=%0d expected 1,0", dc_done_cnt, ic_done_cnt);
    end
    n_vec++;
    if (q_iss.size() < 8 || q_iss[0] !== 16'h0200 || q_iss[7] !== 16'h020E || q_dc_ret.size() != 8) begin
      n_err++; $display("FAIL tie_dc_fill: got issues=%0d dc_ret=%0d expected 8 issues 0200..020E, 8 returns",
                        q_iss.size(), q_dc_ret.size());
    end
    wait_done(1'b0, ok);
    ic_req = 1'b0;
    n_vec++;
    if (!ok || ic_rise != dc_done_cyc + 2) begin
      n_err++; $display("FAIL tie_ic_after_idle: got ic grant cycle %0d expected %0d", ic_rise, dc_done_cyc + 2);
    end
    n_vec++;
    if (n_viol != 0) begin n_err++; $display("FAIL tie_protocol: got %0d violations expected 0", n_viol); end
    repeat (2) step();
  endtask

  task automatic test_write();
    bit ok;
    clear_mon();
    dc_addr = 16'h0041; dc_wdata = 16'hBEEF; dc_wr = 1'b1; dc_req = 1'b1;
    wait_done(1'b1, ok);
    dc_req = 1'b0; dc_wr = 1'b0;
    n_vec++;
    if (!ok || q_wr.size() != 1 || q_wr[0] !== {16'h0040, 16'hBEEF}) begin
      n_err++; $display("FAIL write_bus: got n=%0d first=%h expected 1 write 0040/BEEF",
                        q_wr.size(), q_wr.size() ? q_wr[0] : 32'h0);
    end
    n_vec++;
    if (dc_done_cyc != wr_cyc + 1 || q_dc_ret.size() != 0 || q_iss.size() != 0) begin
      n_err++; $display("FAIL write_done: got done_cyc=%0d wr_cyc=%0d dc_ret=%0d reads=%0d expected done=wr+1, 0, 0",
                        dc_done_cyc, wr_cyc, q_dc_ret.size(), q_iss.size());
    end
    repeat (2) step();
  endtask

  task automatic test_wrap();
    bit ok;
    bit bad;
    clear_mon();
    dc_addr = 16'hFFF6; dc_wr = 1'b0; dc_req = 1'b1;
    wait_done(1'b1, ok);
    dc_req = 1'b0;
    bad = (q_iss.size() != 8);
    for (int i = 0; i < q_iss.size(); i++)
      if (q_iss[i] !== 16'hFFF0 + 16'(2*i)) bad = 1'b1;
    n_vec++;
    if (!ok || bad) begin
      n_err++; $display("FAIL wrap_addr: got issues=%0d last=%h expected 8 issues FFF0..FFFE",
                        q_iss.size(), q_iss.size() ? q_iss[$] : 16'h0);
    end
    n_vec++;
    if (q_dc_ret.size() != 8) begin
      n_err++; $display("FAIL wrap_returns: got %0d expected 8", q_dc_ret.size());
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    ic_addr = 16'h3456; ic_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = (q_ic_ret.size() >= 3);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (!ok || out_vec() !== 72'd0) begin
      n_err++; $display("FAIL reset_mid_outputs: got %h expected 0", out_vec());
    end
    step();
    clear_mon();
    rst_n = 1'b1;
    wait_done(1'b0, ok);
    ic_req = 1'b0;
    n_vec++;
    if (!ok || q_iss.size() != 8 || q_iss[0] !== 16'h3450) begin
      n_err++; $display("FAIL reset_mid_restart: got issues=%0d first=%h expected 8 from 3450",
                        q_iss.size(), q_iss.size() ? q_iss[0] : 16'h0);
    end
    n_vec++;
    if (q_ic_ret.size() != 8 || q_ic_ret[0] !== {3'd0, mem_val(16'h3450)} ||
        q_ic_ret[7] !== {3'd7, mem_val(16'h345E)} || ic_done_cnt != 1) begin
      n_err++; $display("FAIL reset_mid_returns: got n=%0d done=%0d expected 8 words 0..7, 1 done",
                        q_ic_ret.size(), ic_done_cnt);
    end
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    bit exp_g[4];
`ifdef ARB_RR_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    clear_mon();
    ic_addr = 16'h1234; ic_req = 1'b1;
    dc_addr = 16'h0200; dc_wr = 1'b0; dc_req = 1'b1;
    for (int i = 0; i < 400 && (ic_done_cnt + dc_done_cnt) < 4; i++) step();
    ic_req = 1'b0; dc_req = 1'b0;
    n_vec++;
    if (q_grant.size() != 4 || (ic_done_cnt + dc_done_cnt) != 4) begin
      n_err++; $display("FAIL b2b_count: got grants=%0d dones=%0d expected 4,4",
                        q_grant.size(), ic_done_cnt + dc_done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (q_grant[i] !== exp_g[i]) begin
          n_err++; $display("FAIL b2b_grant[%0d]: got side %0d expected %0d (1=D)", i, q_grant[i], exp_g[i]);
        end
      end
    end
    n_vec++;
    if (n_viol != 0) begin n_err++; $display("FAIL b2b_protocol: got %0d violations expected 0", n_viol); end
    repeat (2) step();
  endtask

  initial begin
    clear_mon();
    cyc = 0;
    test_reset();
    test_ic_fill();
    test_tie();
    test_write();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
